// File: rtl/centroid_frame_sequencer.sv
// centroid_frame_sequencer: streams one 64x64 binary frame from the frame
// memory into the centroid accumulator, captures its totals and divides them
// (6-cycle restoring division per axis) into an integer column/row centroid.
// Handshake: START is sampled only in IDLE; BUSY is high outside IDLE; DONE
// pulses for one cycle in FIN, the same cycle CX/CY/EMPTY take new values.
module centroid_frame_sequencer (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic [5:0]  CX,
    output logic [5:0]  CY,
    output logic        EMPTY,
    output logic        MEM_RE,
    output logic [11:0] MEM_ADDR,
    input  logic        MEM_RDATA,
    output logic        CALC_RSTn,
    output logic        CALC_DIN_VALID,
    output logic        CALC_DIN,
    output logic        CALC_LAST,
    input  logic [17:0] CALC_H_TOTAL,
    input  logic [17:0] CALC_V_TOTAL,
    input  logic [12:0] CALC_SUM,
    input  logic        CALC_VALID
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_WAIT,
        S_DIV,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic        empty_q, empty_d;
    logic        mem_re_q, mem_re_d;
    logic [11:0] addr_q, addr_d;
    logic        calc_rstn_q, calc_rstn_d;
    logic        din_valid_q, din_valid_d;
    logic        last_q, last_d;
    logic [17:0] ht_q, ht_d;
    logic [17:0] vt_q, vt_d;
    logic [12:0] s_q, s_d;
    logic [18:0] rem_h_q, rem_h_d;
    logic [18:0] rem_v_q, rem_v_d;
    logic [5:0]  qh_q, qh_d;
    logic [5:0]  qv_q, qv_d;
    logic [2:0]  idx_q, idx_d;

    // Division datapath for the current bit index: divisor shifted into place
    // and the per-axis trial-subtract decision.
    logic [18:0] div_sub;
    logic        h_ge;
    logic        v_ge;
    logic [5:0]  qh_next;
    logic [5:0]  qv_next;

    // One restoring-division step for both axes at bit idx_q.
    always_comb begin
        div_sub = {6'd0, s_q} << idx_q;
        h_ge    = (rem_h_q >= div_sub);
        v_ge    = (rem_v_q >= div_sub);
        qh_next = qh_q | (6'(h_ge) << idx_q);
        qv_next = qv_q | (6'(v_ge) << idx_q);
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        cx_d        = cx_q;
        cy_d        = cy_q;
        empty_d     = empty_q;
        mem_re_d    = mem_re_q;
        addr_d      = addr_q;
        calc_rstn_d = 1'b1;
        din_valid_d = mem_re_q;
        last_d      = 1'b0;
        ht_d        = ht_q;
        vt_d        = vt_q;
        s_d         = s_q;
        rem_h_d     = rem_h_q;
        rem_v_d     = rem_v_q;
        qh_d        = qh_q;
        qv_d        = qv_q;
        idx_d       = idx_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d     = S_CLR;
                    calc_rstn_d = 1'b0;
                end
            end
            S_CLR: begin
                // Address restarts from 0 only here; STREAM never wraps it.
                state_d  = S_STREAM;
                addr_d   = 12'd0;
                mem_re_d = 1'b1;
            end
            S_STREAM: begin
                if (addr_q == 12'd4095) begin
                    // Read of the last pixel is in flight: flag its beat as last.
                    last_d   = 1'b1;
                    mem_re_d = 1'b0;
                    state_d  = S_WAIT;
                end else begin
                    addr_d = addr_q + 12'd1;
                end
            end
            S_WAIT: begin
                if (CALC_VALID) begin
                    ht_d    = CALC_H_TOTAL;
                    vt_d    = CALC_V_TOTAL;
                    s_d     = CALC_SUM;
                    rem_h_d = {1'b0, CALC_H_TOTAL};
                    rem_v_d = {1'b0, CALC_V_TOTAL};
                    qh_d    = 6'd0;
                    qv_d    = 6'd0;
                    idx_d   = 3'd5;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (h_ge) rem_h_d = rem_h_q - div_sub;
                if (v_ge) rem_v_d = rem_v_q - div_sub;
                qh_d = qh_next;
                qv_d = qv_next;
                if (idx_q == 3'd0) begin
                    // Results are published on entry to FIN together with DONE.
                    // An empty frame still runs all six steps for fixed latency.
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    if (s_q == 13'd0) begin
                        cx_d    = 6'd0;
                        cy_d    = 6'd0;
                        empty_d = 1'b1;
                    end else begin
                        cx_d    = qh_next;
                        cy_d    = qv_next;
                        empty_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // BUSY follows the state being entered so it is itself a clean flop.
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cx_q        <= 6'd0;
            cy_q        <= 6'd0;
            empty_q     <= 1'b0;
            mem_re_q    <= 1'b0;
            addr_q      <= 12'd0;
            calc_rstn_q <= 1'b0;
            din_valid_q <= 1'b0;
            last_q      <= 1'b0;
            ht_q        <= 18'd0;
            vt_q        <= 18'd0;
            s_q         <= 13'd0;
            rem_h_q     <= 19'd0;
            rem_v_q     <= 19'd0;
            qh_q        <= 6'd0;
            qv_q        <= 6'd0;
            idx_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            empty_q     <= empty_d;
            mem_re_q    <= mem_re_d;
            addr_q      <= addr_d;
            calc_rstn_q <= calc_rstn_d;
            din_valid_q <= din_valid_d;
            last_q      <= last_d;
            ht_q        <= ht_d;
            vt_q        <= vt_d;
            s_q         <= s_d;
            rem_h_q     <= rem_h_d;
            rem_v_q     <= rem_v_d;
            qh_q        <= qh_d;
            qv_q        <= qv_d;
            idx_q       <= idx_d;
        end
    end

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign CX             = cx_q;
    assign CY             = cy_q;
    assign EMPTY          = empty_q;
    assign MEM_RE         = mem_re_q;
    assign MEM_ADDR       = addr_q;
    assign CALC_RSTn      = calc_rstn_q;
    assign CALC_DIN_VALID = din_valid_q;
    // Memory data is only meaningful on a valid beat; force 0 otherwise.
    assign CALC_DIN       = din_valid_q & MEM_RDATA;
    assign CALC_LAST      = last_q;

endmodule

// File: doc/centroid_frame_sequencer.md
# centroid_frame_sequencer

Controller that sequences one 64x64 binary frame from a 1-bit frame memory into the centroid accumulator and turns the accumulator's totals into an integer centroid. It clears the accumulator before each frame, streams 4096 pixels with the accumulator's valid/last strobes, and captures the H/V totals and pixel count when the accumulator signals valid. It then runs a 6-cycle restoring division for both axes and reports CX, CY and an empty-frame flag with a START/BUSY/DONE handshake. It sits between the IPU frame buffer and the centroid accumulator, under the IPU control registers.

## Interface
- Parameters: none. Frame geometry is fixed at 64x64, matching the accumulator's 6-bit row/column counters.
- CLK  in  1  clock
- RSTn  in  1  reset, synchronous, active-low
- START  in  1  request one frame; sampled only in IDLE
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when CX/CY/EMPTY are updated
- CX  out  6  column centroid, floor(H_TOTAL/SUM)
- CY  out  6  row centroid, floor(V_TOTAL/SUM)
- EMPTY  out  1  last frame had SUM==0
- MEM_RE  out  1  frame-memory read enable
- MEM_ADDR  out  12  pixel address, {row[5:0], col[5:0]}
- MEM_RDATA  in  1  pixel, valid the cycle after MEM_RE
- CALC_RSTn  out  1  accumulator reset (registered, active-low)
- CALC_DIN_VALID  out  1  to accumulator DIN_VALID
- CALC_DIN  out  1  to accumulator DIN
- CALC_LAST  out  1  to accumulator LAST_PIX_VALID
- CALC_H_TOTAL  in  18  accumulator column total
- CALC_V_TOTAL  in  18  accumulator row total
- CALC_SUM  in  13  accumulator pixel count
- CALC_VALID  in  1  accumulator totals final; high one cycle after CALC_LAST

## Operation
- States: IDLE, CLR, STREAM, WAIT, DIV, FIN.
- IDLE: if START=1, go to CLR. START in any other state is ignored; it is not queued.
- CLR (1 cycle): CALC_RSTn=0, address counter cleared to 0, then go to STREAM.
- STREAM (4096 cycles): MEM_RE=1, MEM_ADDR = counter, counter increments each cycle. After issuing address 4095, go to WAIT.
- Pixel path: CALC_DIN_VALID is MEM_RE delayed by 1 cycle. CALC_DIN = MEM_RDATA when CALC_DIN_VALID=1, otherwise 0. CALC_LAST is high together with the CALC_DIN_VALID beat for address 4095.
- WAIT: hold until CALC_VALID=1. On that cycle, latch the three totals into internal registers HT (18), VT (18), S (13), then go to DIV.
- DIV (exactly 6 cycles, i = 5 down to 0):
  - Column axis: if remH >= (S<<i), then remH -= S<<i and qH[i]=1. Row axis is identical on VT.
  - remH/remV start equal to HT/VT. Compare width is 19 bits.
  - The quotient always fits in 6 bits because HT ≤ 63·S.
- FIN (1 cycle):
  - If S==0: CX=0, CY=0, EMPTY=1.
  - Otherwise: CX=qH, CY=qV, EMPTY=0.
  - DONE=1; go to IDLE.
- S==0 still takes the full DIV time, so DONE timing does not depend on the data.
- CX/CY/EMPTY hold their values until the next FIN.

## Timing
- Reset values: BUSY=0, DONE=0, CX=0, CY=0, EMPTY=0, MEM_RE=0, MEM_ADDR=0, CALC_RSTn=0, CALC_DIN_VALID=0, CALC_DIN=0, CALC_LAST=0; state is IDLE.
- CALC_RSTn returns to 1 on the first cycle after RSTn is released and is low again only in CLR.
- Reference cycle: START sampled high in cycle 0 (IDLE). Then:
  - CLR in cycle 1.
  - STREAM in cycles 2..4097; MEM_ADDR equals n in cycle 2+n.
  - CALC_DIN_VALID high in cycles 3..4098; CALC_LAST high in cycle 4098.
  - CALC_VALID high in cycle 4099.
  - DIV in cycles 4100..4105.
  - DONE high in cycle 4106; BUSY low from cycle 4107.
- Start-to-DONE latency: 4106 cycles.
- BUSY goes high in cycle 1.
- A new START is accepted in cycle 4107 at the earliest.
- START held high continuously produces back-to-back frames with one IDLE cycle between them.
- RSTn low in any state: return to IDLE with reset values on the next edge. The partial frame is discarded and no DONE is issued.
- The address counter does not wrap within a frame: STREAM ends at 4095, and address 0 is reloaded only in CLR.

## Test plan
- All-zero frame, START pulse → DONE in cycle 4106 after START; EMPTY=1, CX=0, CY=0; exactly 4096 CALC_DIN_VALID beats and one CALC_LAST.
- Single set pixel at row 10, col 5 (address 645) → SUM=1, HT=5, VT=10; CX=5, CY=10, EMPTY=0.
- All-ones frame → HT=VT=129024, S=4096; CX=31, CY=31 (31.5 truncated).
- Two pixels, (0,0) and (63,63) → CX=31, CY=31; then pixels (2,3) and (2,4) → CX=3, CY=2.
- START pulsed in cycles 100 and 4106 while BUSY → both ignored; only one DONE; MEM_ADDR sequence unaffected.
- RSTn low for 1 cycle at cycle 2000 of STREAM → BUSY=0 and CALC_RSTn=0 while reset; no DONE; the next START yields correct results for a fresh frame (CALC_RSTn low in CLR).
